// File: rtl/bus_wait_ram_pkg.sv
// Shared definitions for the wait-state RAM responder on the mpu bus:
// bus widths, controller state encoding and the latched access key.
package bus_wait_ram_pkg;

  localparam int AB_W = 16;
  localparam int DB_W = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // An access is identified by its address and direction; any change aborts it.
  typedef struct packed {
    logic [AB_W-1:0] addr;
    logic            r_w;
  } key_t;

endpackage

// File: rtl/bus_wait_ctrl.sv
// Wait-state controller: sequences IDLE/WAIT/ACK per access, holds RDY low for
// WAIT_CYCLES cycles, aborts on a changed address/direction, strobes the write commit.
module bus_wait_ctrl
  import bus_wait_ram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic hit,
  input  key_t key,
  output logic rdy,
  output logic commit
);

  localparam logic [CNT_W-1:0] RELOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  key_t             key_q, key_nxt;
  logic             start;
  logic             changed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (res) begin
      state <= ST_IDLE;
      cnt   <= '0;
      key_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      key_q <= key_nxt;
    end
  end

  assign changed = (key != key_q);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    key_nxt   = key_q;
    rdy       = 1'b1;
    start     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (hit && WAIT_CYCLES != 0) start = 1'b1;
      end
      ST_WAIT: begin
        if (changed) begin
          if (hit) start = 1'b1;
          else     state_nxt = ST_IDLE;
        end else begin
          rdy     = 1'b0;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (changed && hit) start = 1'b1;
        else                state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A new access (fresh or replacing an abandoned one) reloads the countdown.
    if (start) begin
      rdy       = 1'b0;
      key_nxt   = key;
      cnt_nxt   = RELOAD;
      state_nxt = (WAIT_CYCLES == 1) ? ST_ACK : ST_WAIT;
    end

    if (res) rdy = 1'b1;
  end

  assign commit = rdy & hit & ~key.r_w & ~res;

endmodule

// File: rtl/bus_wait_ram.sv
// Wait-state RAM responder: decodes an aligned address window, backs it with a
// byte RAM and stalls the mpu for WAIT_CYCLES cycles per access via RDY.
module bus_wait_ram
  import bus_wait_ram_pkg::*;
#(
  parameter logic [AB_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int              ADDR_WIDTH  = 12,
  parameter int              WAIT_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic [7:0]      ABL,
  input  logic [7:0]      ABH,
  input  logic            R_W,
  input  logic [DB_W-1:0] DB_OUT,
  output logic [DB_W-1:0] DB_IN,
  output logic            RDY,
  output logic            SEL
);

  localparam logic [AB_W-1:0] WIN_MASK = AB_W'((1 << ADDR_WIDTH) - 1);

  logic [AB_W-1:0]       addr;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  hit;
  logic                  commit;
  key_t                  key;
  logic [DB_W-1:0]       mem [0:(1 << ADDR_WIDTH) - 1];

  assign addr = {ABH, ABL};
  assign idx  = addr[ADDR_WIDTH-1:0];
  assign hit  = (addr & ~WIN_MASK) == BASE_ADDR;
  assign SEL  = hit & ~RES;
  assign key  = '{addr: addr, r_w: R_W};

  bus_wait_ctrl #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_ctrl (
    .clk    (CLK),
    .res    (RES),
    .hit    (hit),
    .key    (key),
    .rdy    (RDY),
    .commit (commit)
  );

  // NOTE: the RAM array has no reset; clearing it would turn it into
  // thousands of flops instead of a memory macro.
  always_ff @(posedge CLK) begin
    if (commit) mem[idx] <= DB_OUT;
  end

  // Zero when deselected so several responders can be ORed onto DB_IN.
  assign DB_IN = (SEL && R_W) ? mem[idx] : '0;

endmodule

// File: tb/tb_bus_wait_ram.sv
// Self-checking bench for bus_wait_ram: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances,
// read data scored through an expected-value queue against a reference memory.
module tb_bus_wait_ram;

  localparam int W = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       res, r_w, rdy, sel;
  logic [7:0] abl, abh, db_out, db_in;

  logic       z_res, z_r_w, z_rdy, z_sel;
  logic [7:0] z_abl, z_abh, z_db_out, z_db_in;

  bus_wait_ram #(.BASE_ADDR(16'h0000), .ADDR_WIDTH(12), .WAIT_CYCLES(W)) u_dut (
    .CLK(clk), .RES(res), .ABL(abl), .ABH(abh), .R_W(r_w),
    .DB_OUT(db_out), .DB_IN(db_in), .RDY(rdy), .SEL(sel)
  );

  bus_wait_ram #(.BASE_ADDR(16'h0000), .ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_w0 (
    .CLK(clk), .RES(z_res), .ABL(z_abl), .ABH(z_abh), .R_W(z_r_w),
    .DB_OUT(z_db_out), .DB_IN(z_db_in), .RDY(z_rdy), .SEL(z_sel)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] ref_mem [int];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
    {abh, abl} = a;
    r_w        = rw;
    db_out     = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected <empty scoreboard>", tag, db_in);
    end else begin
      check(tag, db_in, exp_q.pop_front());
    end
  endtask

  // One complete access held for W+1 cycles; RDY must be low until the last.
  task automatic run_access(input string tag, input logic [15:0] a,
                            input logic rw, input logic [7:0] d);
    int idx;
    idx = int'(a[11:0]);
    drive(a, rw, d);
    if (rw) exp_q.push_back(ref_mem[idx]);
    for (int c = 0; c <= W; c++) begin
      @(negedge clk);
      check({tag, " rdy"}, rdy, c == W);
      check({tag, " sel"}, sel, 1'b1);
      if (!rw && ref_mem.exists(idx))
        check({tag, " ram before ack"}, u_dut.mem[a[11:0]], ref_mem[idx]);
      if (rw && c == W) pop_check({tag, " data"});
      step();
    end
    if (!rw) begin
      ref_mem[idx] = d;
      check({tag, " ram after ack"}, u_dut.mem[a[11:0]], d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b1;
    z_res = 1'b1;
    drive(16'h0010, 1'b1, 8'h00);
    {z_abh, z_abl} = 16'h0010;
    z_r_w = 1'b1;
    z_db_out = 8'h00;
    step();
    step();
    @(negedge clk);
    check("reset rdy", rdy, 1'b1);
    check("reset sel", sel, 1'b0);
    check("reset db_in", db_in, 8'h00);
    check("w0 reset rdy", z_rdy, 1'b1);
    check("w0 reset sel", z_sel, 1'b0);
    step();
    res = 1'b0;
    z_res = 1'b0;

    // Miss: always ready, never selected, bus idle at zero.
    drive(16'hF000, 1'b1, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("miss rdy", rdy, 1'b1);
      check("miss sel", sel, 1'b0);
      check("miss db_in", db_in, 8'h00);
      step();
    end

    run_access("wr010", 16'h0010, 1'b0, 8'hA5);
    run_access("wr030", 16'h0030, 1'b0, 8'h11);
    run_access("wr040", 16'h0040, 1'b0, 8'h5A);
    run_access("wr050", 16'h0050, 1'b0, 8'h22);
    run_access("wr060", 16'h0060, 1'b0, 8'h66);
    run_access("wr020a", 16'h0020, 1'b0, 8'h00);

    run_access("rd010", 16'h0010, 1'b1, 8'h00);
    run_access("wr020", 16'h0020, 1'b0, 8'h3C);
    run_access("rd020", 16'h0020, 1'b1, 8'h00);
    run_access("rd010 b2b1", 16'h0010, 1'b1, 8'h00);
    run_access("rd010 b2b2", 16'h0010, 1'b1, 8'h00);

    // Abandoned write replaced by a read: RDY 0,0,0,1 from write start.
    drive(16'h0030, 1'b0, 8'h77);
    @(negedge clk);
    check("abort wr rdy", rdy, 1'b0);
    step();
    drive(16'h0040, 1'b1, 8'h00);
    exp_q.push_back(ref_mem[12'h040]);
    for (int c = 0; c <= W; c++) begin
      @(negedge clk);
      check("abort rd rdy", rdy, c == W);
      if (c == W) pop_check("abort rd data");
      step();
    end
    check("abort ram030", u_dut.mem[12'h030], ref_mem[12'h030]);

    // Abandoned write replaced by a miss: ready at once, nothing written.
    drive(16'h0060, 1'b0, 8'h99);
    @(negedge clk);
    check("abort miss wr rdy", rdy, 1'b0);
    step();
    drive(16'hF000, 1'b1, 8'h00);
    @(negedge clk);
    check("abort miss rdy", rdy, 1'b1);
    check("abort miss sel", sel, 1'b0);
    step();
    check("abort miss ram060", u_dut.mem[12'h060], ref_mem[12'h060]);

    // Reset in the middle of a write drops it; the held access restarts.
    drive(16'h0050, 1'b0, 8'h99);
    @(negedge clk);
    check("rst wr rdy", rdy, 1'b0);
    step();
    res = 1'b1;
    @(negedge clk);
    check("rst mid rdy", rdy, 1'b1);
    check("rst mid sel", sel, 1'b0);
    check("rst mid db_in", db_in, 8'h00);
    step();
    res = 1'b0;
    check("rst dropped ram050", u_dut.mem[12'h050], ref_mem[12'h050]);
    run_access("wr050 restart", 16'h0050, 1'b0, 8'h99);
    run_access("rd050", 16'h0050, 1'b1, 8'h00);

    // Zero-wait instance: every hit completes in its own cycle.
    {z_abh, z_abl} = 16'h0100;
    z_r_w = 1'b0;
    z_db_out = 8'hC3;
    @(negedge clk);
    check("w0 wr rdy", z_rdy, 1'b1);
    check("w0 wr sel", z_sel, 1'b1);
    step();
    check("w0 wr ram", u_w0.mem[12'h100], 8'hC3);
    z_r_w = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("w0 rd rdy", z_rdy, 1'b1);
      check("w0 rd data", z_db_in, 8'hC3);
      step();
    end
    {z_abh, z_abl} = 16'hF000;
    @(negedge clk);
    check("w0 miss rdy", z_rdy, 1'b1);
    check("w0 miss sel", z_sel, 1'b0);
    step();

    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
